// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - core request ports and SRAM pin bundle for sram_arbiter
interface sram_arbiter_if #(
  parameter int ADDR_W = 20
);
  // instruction-fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              if_ack;

  // data-memory port
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  // SRAM pins (bus tristate resolved at top level through sram_data_oe)
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;
  logic              sram_data_oe;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic [3:0]        sram_be_n;

  // arbiter side
  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_be, mem_addr, mem_wdata, sram_rdata,
    output if_rdata, if_ack, mem_rdata, mem_ack,
    output sram_addr, sram_wdata, sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
  );

  // core / board side
  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_be, mem_addr, mem_wdata, sram_rdata,
    input  if_rdata, if_ack, mem_rdata, mem_ack,
    input  sram_addr, sram_wdata, sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
  );
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin fetch/data arbiter sequencing one async SRAM bank
module sram_arbiter #(
  parameter int ADDR_W    = 20,
  parameter int RD_CYCLES = 2,
  parameter int WR_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  sram_arbiter_if.slave   bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] READ   = 3'd1;
  localparam logic [2:0] WSETUP = 3'd2;
  localparam logic [2:0] WPULSE = 3'd3;
  localparam logic [2:0] WHOLD  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  localparam logic FETCH = 1'b0;
  localparam logic DATA  = 1'b1;

  localparam int MAXC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] RD_LAST = CW'(RD_CYCLES - 1);
  localparam logic [CW-1:0] WR_LAST = CW'(WR_CYCLES - 1);

  logic [2:0]        state;
  logic [CW-1:0]     cnt;
  logic              last_grant;
  logic              grant;
  logic [ADDR_W-1:0] lat_addr;
  logic [3:0]        lat_be;
  logic [31:0]       lat_wdata;
  logic [31:0]       if_rdata_r;
  logic [31:0]       mem_rdata_r;

  logic              any_req;
  logic              pick_data;

  // Arbitration: a lone request wins; on a tie the port not served last time wins.
  always_comb begin
    any_req = bus.if_req | bus.mem_req;
    if (bus.if_req && bus.mem_req) begin
      pick_data = (last_grant == FETCH);
    end else begin
      pick_data = bus.mem_req;
    end
  end

  // Transaction sequencer: latches the granted request and walks the strobe phases.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      last_grant  <= DATA;
      grant       <= FETCH;
      lat_addr    <= '0;
      lat_be      <= 4'h0;
      lat_wdata   <= 32'h0;
      if_rdata_r  <= 32'h0;
      mem_rdata_r <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant      <= pick_data;
            last_grant <= pick_data;
            cnt        <= '0;
            if (pick_data == DATA) begin
              lat_addr  <= bus.mem_addr;
              lat_be    <= bus.mem_be;
              lat_wdata <= bus.mem_wdata;
              state     <= bus.mem_we ? WSETUP : READ;
            end else begin
              lat_addr <= bus.if_addr;
              lat_be   <= 4'hF;
              state    <= READ;
            end
          end
        end
        READ: begin
          if (cnt == RD_LAST) begin
            if (grant == DATA) begin
              mem_rdata_r <= bus.sram_rdata;
            end else begin
              if_rdata_r <= bus.sram_rdata;
            end
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WSETUP: begin
          cnt   <= '0;
          state <= WPULSE;
        end
        WPULSE: begin
          if (cnt == WR_LAST) begin
            state <= WHOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WHOLD: begin
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Strobe decode straight from state so an async reset releases the bus immediately;
  // data_oe is only ever raised in write phases, where oe_n is held high.
  always_comb begin
    bus.sram_ce_n    = 1'b1;
    bus.sram_oe_n    = 1'b1;
    bus.sram_we_n    = 1'b1;
    bus.sram_be_n    = 4'hF;
    bus.sram_data_oe = 1'b0;
    case (state)
      READ: begin
        bus.sram_ce_n = 1'b0;
        bus.sram_oe_n = 1'b0;
        bus.sram_be_n = ~lat_be;
      end
      WSETUP, WHOLD: begin
        bus.sram_ce_n    = 1'b0;
        bus.sram_be_n    = ~lat_be;
        bus.sram_data_oe = 1'b1;
      end
      WPULSE: begin
        bus.sram_ce_n    = 1'b0;
        bus.sram_we_n    = 1'b0;
        bus.sram_be_n    = ~lat_be;
        bus.sram_data_oe = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.sram_addr  = lat_addr;
  assign bus.sram_wdata = lat_wdata;
  assign bus.if_rdata   = if_rdata_r;
  assign bus.mem_rdata  = mem_rdata_r;
  assign bus.if_ack     = (state == DONE) && (grant == FETCH);
  assign bus.mem_ack    = (state == DONE) && (grant == DATA);

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares one 32-bit asynchronous SRAM bank (BaseRAM) between the CPU instruction-fetch port and the data-memory port.
- Sequences multi-cycle SRAM read/write strobes and returns a one-cycle ack per port.
- Sits between the GeMIPS core ports and the board SRAM pins.
- Tristate resolution of the data bus stays at top level, driven by sram_data_oe.

Parameters:
ADDR_W, 20, SRAM word-address width
RD_CYCLES, 2, cycles ce_n/oe_n held low before read data is sampled (>=1)
WR_CYCLES, 2, cycles we_n held low (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
if_req  in  1  fetch request, held until if_ack
if_addr  in  ADDR_W  fetch word address
if_rdata  out  32  fetch read data, valid with if_ack, held until next fetch completion
if_ack  out  1  one-cycle fetch completion pulse
mem_req  in  1  data request, held until mem_ack
mem_we  in  1  1=write, 0=read
mem_be  in  4  byte enables, active high
mem_addr  in  ADDR_W  data word address
mem_wdata  in  32  write data
mem_rdata  out  32  data read data, valid with mem_ack, held until next data read completion
mem_ack  out  1  one-cycle data completion pulse
sram_addr  out  ADDR_W  SRAM address
sram_wdata  out  32  SRAM write data
sram_rdata  in  32  SRAM read data
sram_data_oe  out  1  1=top drives sram_wdata onto bus
sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM strobes, active low
sram_be_n  out  4  SRAM byte enables, active low

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; all strobes=1; sram_be_n=4'hF; sram_data_oe=0.
  - Both acks=0; both rdata=0; sram_addr=0; sram_wdata=0.
  - last_grant=DATA, so fetch wins the first tie.
- Reset mid-operation aborts at once: strobes deassert, no ack is issued.
- States: IDLE, READ, WSETUP, WPULSE, WHOLD, DONE.
- IDLE: arbitration.
  - Only one request pending: grant it.
  - Both pending: grant the port not equal to last_grant (round robin); update last_grant.
  - Latch address, be, wdata, we, and granted port.
  - Fetch is always a read with be=4'hF.
- READ, RD_CYCLES cycles:
  - ce_n=0, oe_n=0, we_n=1, be_n=~be.
  - On the last cycle's edge, sram_rdata is captured into the granted port's rdata register; go to DONE.
- WSETUP, 1 cycle: ce_n=0, oe_n=1, we_n=1, sram_data_oe=1, address and data driven.
- WPULSE, WR_CYCLES cycles: as WSETUP, plus we_n=0.
- WHOLD, 1 cycle: we_n=1; ce_n=0, data_oe=1, address and data still driven (hold time).
- DONE, 1 cycle: ce_n=1; granted port's ack=1; next state IDLE.
  - No new grant in DONE; the requester deasserts req on the ack cycle.
- Latency from IDLE grant edge to ack high:
  - Read: RD_CYCLES+1 cycles.
  - Write: WR_CYCLES+3 cycles.
- A req still high in IDLE after DONE is a new request.
- A write updates no rdata register.
- Address, data and be are stable for the whole transaction from latched copies; input changes mid-transaction are ignored.
- A req dropped before ack: the transaction still completes and ack still pulses.
- sram_data_oe=0 in all states except WSETUP, WPULSE and WHOLD. It is never 1 while oe_n=0 (no bus contention).
- Acks are mutually exclusive, never both high.

Test Plan:
- Reset → all strobes=1, be_n=F, data_oe=0, acks=0, state IDLE; assert rst=0 mid-WPULSE → we_n=1 and data_oe=0 same cycle, no mem_ack.
- Lone fetch, if_addr=0x00010, sram_rdata=0x3C011234 → ce_n/oe_n low 2 cycles, if_ack at cycle 3 after grant, if_rdata=0x3C011234 held afterwards.
- Data write addr=0x00020, be=4'b0011, wdata=0xDEADBEEF → 1 setup, 2 we_n-low cycles, 1 hold; be_n=4'b1100; data_oe=1 throughout; mem_ack at cycle 5.
- Simultaneous if_req and mem_req from reset → fetch granted first, data second, then fetch again on repeat. Continuous mem_req never starves if_req: alternating grants.
- Data read during pending fetch → mem_rdata updated, if_rdata unchanged; only mem_ack pulses.
- Monitor over randomized traffic → never data_oe=1 with oe_n=0, never both acks high, ack width exactly 1 cycle.
